// File: rtl/rr_dispatcher_if.sv
// Flit stream bundle between one upstream source and the N-way dispatcher fan-out.
// slave is the dispatcher side; master is the side that drives flits in and readies back.
interface rr_dispatcher_if #(
  parameter int N_OF_OUTPUTS = 2,
  parameter int FLIT_WIDTH   = 34
);
  logic [FLIT_WIDTH-1:0]   flit_i;
  logic                    valid_i;
  logic                    tail_i;
  logic                    ready_o;
  logic [FLIT_WIDTH-1:0]   flit_o;
  logic [N_OF_OUTPUTS-1:0] valid_o;
  logic [N_OF_OUTPUTS-1:0] ready_i;
  logic                    locked_o;

  modport slave (
    input  flit_i, valid_i, tail_i, ready_i,
    output ready_o, flit_o, valid_o, locked_o
  );

  modport master (
    output flit_i, valid_i, tail_i, ready_i,
    input  ready_o, flit_o, valid_o, locked_o
  );
endinterface

// File: rtl/rr_dispatcher.sv
// Round-robin 1-to-N flit dispatcher with packet locking and a single output register stage.
// state     | meaning
// ST_IDLE   | between packets; next accepted flit picks a target round-robin
// ST_LOCKED | mid-packet; every flit goes to lock_tgt_ff until the tail is accepted
module rr_dispatcher #(
  parameter int N_OF_OUTPUTS = 2,
  parameter int FLIT_WIDTH   = 34
) (
  input logic            clk,
  input logic            arst_n,
  rr_dispatcher_if.slave bus
);
  localparam int PTR_W = (N_OF_OUTPUTS > 1) ? $clog2(N_OF_OUTPUTS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_OF_OUTPUTS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_ff;
  state_t                state_nxt;
  logic                  vld_ff;
  logic [PTR_W-1:0]      tgt_ff;
  logic [FLIT_WIDTH-1:0] flit_ff;
  logic [PTR_W-1:0]      lock_tgt_ff;
  logic [PTR_W-1:0]      ptr_ff;

  logic [PTR_W-1:0]      sel_tgt;
  logic                  sel_found;
  logic [PTR_W-1:0]      scan_idx;
  logic [PTR_W-1:0]      target;
  logic                  in_xfer;
  logic                  out_xfer;

  assign out_xfer    = vld_ff && bus.ready_i[tgt_ff];
  assign bus.ready_o = !vld_ff || bus.ready_i[tgt_ff];
  assign in_xfer     = bus.valid_i && bus.ready_o;
  assign bus.flit_o  = flit_ff;

  // First ready port at or after ptr_ff; falls back to ptr_ff when nobody is ready.
  always_comb begin
    sel_tgt   = ptr_ff;
    sel_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < N_OF_OUTPUTS; i++) begin
      scan_idx = PTR_W'((int'(ptr_ff) + i) % N_OF_OUTPUTS);
      if (!sel_found && bus.ready_i[scan_idx]) begin
        sel_tgt   = scan_idx;
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_ff <= ST_IDLE;
    else         state_ff <= state_nxt;
  end

  always_comb begin
    state_nxt    = state_ff;
    target       = sel_tgt;
    bus.locked_o = 1'b0;
    case (state_ff)
      ST_IDLE: begin
        if (in_xfer && !bus.tail_i) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        target       = lock_tgt_ff;
        bus.locked_o = 1'b1;
        if (in_xfer && bus.tail_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.valid_o = '0;
    if (vld_ff) bus.valid_o[tgt_ff] = 1'b1;
  end

  // A simultaneous in/out transfer just overwrites the buffer, so there is no bubble.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_ff      <= 1'b0;
      tgt_ff      <= '0;
      flit_ff     <= '0;
      lock_tgt_ff <= '0;
      ptr_ff      <= '0;
    end else begin
      if (in_xfer) begin
        flit_ff <= bus.flit_i;
        tgt_ff  <= target;
        vld_ff  <= 1'b1;
      end else if (out_xfer) begin
        vld_ff  <= 1'b0;
      end
      if (in_xfer && (state_ff == ST_IDLE) && !bus.tail_i)
        lock_tgt_ff <= target;
      if (in_xfer && bus.tail_i)
        ptr_ff <= (target == LAST_IDX) ? '0 : target + PTR_W'(1);
    end
  end
endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed and random stimulus for rr_dispatcher (N=4) checked against a behavioural model.
module tb_rr_dispatcher;
  localparam int N     = 4;
  localparam int FW    = 34;
  localparam int BOUND = 50;

  logic clk;
  logic arst_n;

  rr_dispatcher_if #(.N_OF_OUTPUTS(N), .FLIT_WIDTH(FW)) bus ();

  rr_dispatcher #(.N_OF_OUTPUTS(N), .FLIT_WIDTH(FW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one-entry buffer, lock owner (-1 when between packets), rr pointer.
  bit            m_vld;
  int            m_tgt;
  logic [FW-1:0] m_flit;
  int            m_lock;
  int            m_ptr;
  bit            m_acc;
  bit            toggle_r0;

  typedef struct { int port; logic [FW-1:0] flit; } out_t;
  out_t out_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [N-1:0] rdy);
    if (m_lock >= 0) return m_lock;
    for (int i = 0; i < N; i++)
      if (rdy[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return m_ptr;
  endfunction

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_tgt = 0; m_flit = '0; m_lock = -1; m_ptr = 0; m_acc = 0;
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    logic          exp_ready;
    logic [N-1:0]  exp_valid;
    bit            n_vld, in_x, out_x;
    int            n_tgt, n_lock, n_ptr, tgt;
    logic [FW-1:0] n_flit;
    #1;
    exp_ready = !m_vld || bus.ready_i[m_tgt];
    exp_valid = m_vld ? onehot(m_tgt) : '0;
    check("ready_o",  64'(bus.ready_o),  64'(exp_ready));
    check("valid_o",  64'(bus.valid_o),  64'(exp_valid));
    check("locked_o", 64'(bus.locked_o), 64'(m_lock >= 0));
    check("flit_o",   64'(bus.flit_o),   64'(m_flit));
    for (int k = 0; k < N; k++)
      if (bus.valid_o[k] && bus.ready_i[k]) out_log.push_back('{k, bus.flit_o});
    in_x  = bus.valid_i && exp_ready;
    out_x = m_vld && bus.ready_i[m_tgt];
    tgt   = pick(bus.ready_i);
    n_vld = m_vld; n_tgt = m_tgt; n_flit = m_flit; n_lock = m_lock; n_ptr = m_ptr;
    if (in_x) begin
      n_vld = 1; n_tgt = tgt; n_flit = bus.flit_i;
      if (bus.tail_i) begin
        n_lock = -1;
        n_ptr  = (tgt + 1) % N;
      end else begin
        n_lock = tgt;
      end
    end else if (out_x) begin
      n_vld = 0;
    end
    @(posedge clk);
    m_vld = n_vld; m_tgt = n_tgt; m_flit = n_flit; m_lock = n_lock; m_ptr = n_ptr; m_acc = in_x;
    @(negedge clk);
    if (toggle_r0) bus.ready_i[0] = ~bus.ready_i[0];
  endtask

  task automatic send_flit(input logic [FW-1:0] f, input logic t, output int cyc);
    bus.flit_i = f; bus.tail_i = t; bus.valid_i = 1'b1; cyc = 0;
    do begin
      step();
      cyc++;
    end while (!m_acc && cyc < BOUND);
    if (!m_acc) begin
      n_checks++;
      $error("FAIL accept_timeout: no acceptance within %0d cycles", BOUND);
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid_o",  64'(bus.valid_o),  64'(0));
    check("rst_locked_o", 64'(bus.locked_o), 64'(0));
    check("rst_ready_o",  64'(bus.ready_o),  64'(1));
    check("rst_flit_o",   64'(bus.flit_o),   64'(0));
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    int            cyc;
    logic [63:0]   rnd;
    logic [N-1:0]  seq [5];
    logic [N-1:0]  held_valid;
    arst_n = 1'b0;
    bus.flit_i = '0; bus.valid_i = 1'b0; bus.tail_i = 1'b0; bus.ready_i = '0;
    toggle_r0 = 0;
    model_reset();
    @(negedge clk);

    // 1: reset, quiet for 10 cycles
    do_reset();
    idle(10);

    // 2: five single-flit packets, all ready
    bus.ready_i = 4'b1111;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      send_flit(34'h100 + 34'(i), 1'b1, cyc);
      check("t2_latency", 64'(cyc), 64'(1));
      check("t2_valid_seq", 64'(bus.valid_o), 64'(seq[i]));
    end
    idle(3);

    // 3: 3-flit packet with ready_i[0] toggling; stays on port 0
    do_reset();
    out_log.delete();
    bus.ready_i = 4'b0011;
    toggle_r0 = 1;
    send_flit(34'h2_0000_0001, 1'b0, cyc);
    check("t3_locked_head", 64'(bus.locked_o), 64'(1));
    send_flit(34'h2_0000_0002, 1'b0, cyc);
    check("t3_locked_mid", 64'(bus.locked_o), 64'(1));
    send_flit(34'h2_0000_0003, 1'b1, cyc);
    check("t3_unlocked", 64'(bus.locked_o), 64'(0));
    send_flit(34'h2_0000_0004, 1'b1, cyc);
    check("t3_next_head_port1", 64'(bus.valid_o), 64'(4'b0010));
    toggle_r0 = 0;
    bus.ready_i = 4'b1111;
    idle(3);
    check("t3_out_count", 64'(out_log.size()), 64'(4));
    if (out_log.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        check("t3_out_port", 64'(out_log[i].port), 64'(0));
        check("t3_out_flit", 64'(out_log[i].flit), 64'(34'h2_0000_0001 + 34'(i)));
      end
      check("t3_head_port", 64'(out_log[3].port), 64'(1));
    end

    // 4: ptr=1, ready 1001 -> port 3, then wrap to port 0
    do_reset();
    bus.ready_i = 4'b1111;
    send_flit(34'h300, 1'b1, cyc);
    idle(2);
    bus.ready_i = 4'b1001;
    send_flit(34'h301, 1'b1, cyc);
    check("t4_port3", 64'(bus.valid_o), 64'(4'b1000));
    idle(2);
    bus.ready_i = 4'b1111;
    send_flit(34'h302, 1'b1, cyc);
    check("t4_wrap_port0", 64'(bus.valid_o), 64'(4'b0001));
    idle(2);

    // 5: buffer held with no readies, then drain and full rate
    bus.ready_i = 4'b0000;
    send_flit(34'h3_AAAA_0000, 1'b1, cyc);
    held_valid = onehot(m_tgt);
    bus.flit_i = 34'h1_5555_0000; bus.tail_i = 1'b1; bus.valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t5_ready_low",   64'(bus.ready_o), 64'(0));
      check("t5_flit_stable", 64'(bus.flit_o),  64'(34'h3_AAAA_0000));
      check("t5_valid_stable", 64'(bus.valid_o), 64'(held_valid));
    end
    bus.ready_i = 4'b1111;
    send_flit(34'h1_5555_0000, 1'b1, cyc);
    check("t5_resume_latency", 64'(cyc), 64'(1));
    for (int i = 0; i < 4; i++) begin
      send_flit(34'h500 + 34'(i), 1'b1, cyc);
      check("t5_full_rate", 64'(cyc), 64'(1));
    end
    idle(2);

    // 6: reset after the 2nd flit of a 4-flit packet
    bus.ready_i = 4'b1111;
    send_flit(34'h600, 1'b0, cyc);
    send_flit(34'h601, 1'b0, cyc);
    arst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_valid",  64'(bus.valid_o),  64'(0));
    check("t6_rst_locked", 64'(bus.locked_o), 64'(0));
    @(negedge clk);
    arst_n = 1'b1;
    send_flit(34'h610, 1'b0, cyc);
    check("t6_head_port0", 64'(bus.valid_o), 64'(4'b0001));
    send_flit(34'h611, 1'b1, cyc);
    idle(2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom};
      bus.flit_i  = rnd[FW-1:0];
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.tail_i  = ($urandom_range(0, 2) == 0);
      bus.ready_i = ($urandom_range(0, 7) == 0) ? 4'b0000 : N'($urandom_range(0, 15));
      step();
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
